mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Memory-side neighbour of the 16-bit pipelined cpu: serves the cpu instruction
//   fetch port (Baddr/BmemRead) and data port (MeAaddr/MeMemControl/AmemRead).
//   Both ports share one external asynchronous 16-bit SRAM. Data access goes
//   first, then instruction fetch. stall freezes the cpu pipeline until both
//   results are valid.
// PARAMETERS
//   ADDR_W       16  address width, cpu side and SRAM side
//   DATA_W       16  data word width
//   WAIT_CYCLES  1   extra SRAM cycles per access; access length T = WAIT_CYCLES+1
// PORTS
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous, active-low reset
//   Baddr        in   ADDR_W  instruction fetch address from cpu
//   BmemRead     out  DATA_W  fetched instruction word, registered
//   MeAaddr      in   ADDR_W  data access address from cpu MEM stage
//   MeMemWrite   in   DATA_W  store data from cpu
//   MeMemControl in   2       00 none, 01 read, 10 write, 11 reserved (= none)
//   AmemRead     out  DATA_W  load result, registered
//   stall        out  1       1 = cpu must hold all pipeline registers
//   sram_addr    out  ADDR_W  SRAM address, registered
//   sram_dq_out  out  DATA_W  SRAM write data
//   sram_dq_oe   out  1       1 = drive SRAM data bus (tri-state enable)
//   sram_dq_in   in   DATA_W  SRAM read data
//   sram_ce_n    out  1       chip enable, active-low
//   sram_oe_n    out  1       output enable, active-low
//   sram_we_n    out  1       write enable, active-low
// BEHAVIOUR
//   Reset (rst=0, async): state=ARB, counter=0, BmemRead=0, AmemRead=0,
//     sram_addr=0, sram_dq_out=0, sram_dq_oe=0, ce_n/oe_n/we_n=1.
//     stall=1 while in reset and whenever state!=DONE.
//   FSM states: ARB, DATA, FETCH, DONE. Each state is one or more cycles.
//   ARB (1 cycle): latch Baddr, MeAaddr, MeMemWrite and MeMemControl. Next state
//     is DATA if the latched op is 01 or 10, otherwise FETCH.
//   DATA (T cycles): ce_n=0, sram_addr=latched MeAaddr.
//     read : oe_n=0; capture sram_dq_in into AmemRead on the last-cycle edge.
//     write: sram_dq_oe=1 and dq_out=latched data for all T cycles. we_n=0 for
//       the first T-1 cycles (T=1: one cycle) and we_n=1 on the last cycle as hold.
//       AmemRead is unchanged.
//     Next state: FETCH.
//   FETCH (T cycles): ce_n=0, oe_n=0, sram_addr=latched Baddr; capture sram_dq_in
//     into BmemRead on the last-cycle edge. Next state: DONE.
//   DONE (1 cycle): stall=0, all strobes inactive. The cpu advances on this edge.
//     Next state: ARB.
//   Cycle cost per cpu step: 2+T with no data op, 2+2T with a data op
//     (defaults: 4 and 6 cycles).
//   Cpu inputs are sampled only in ARB; changes while stall=1 are ignored.
//   Counter counts 0..T-1 and clears on every state change.
//   Reserved op 11 behaves exactly like 00: no SRAM cycle, AmemRead unchanged.
//   Results stay stable from their capture edge until the next capture.
//   Reset mid-access: strobes deassert at once, the access is abandoned, and
//     after release the FSM restarts from ARB.
//   The oe_n=0 and we_n=0 cycles never overlap. dq_oe=1 only during DATA write.
// TESTING
//   1 Reset: hold rst=0 for 5 cycles -> stall=1, BmemRead=AmemRead=0, all _n=1,
//     dq_oe=0.
//   2 Fetch only: Baddr=0x0010, ctrl=00, SRAM[0x0010]=0x0800 -> stall=0 on
//     cycle 4 after ARB entry, BmemRead=0x0800, ce_n/oe_n low exactly 2 cycles.
//   3 Load: MeAaddr=0x8000 with SRAM=0x1234, ctrl=01, Baddr=0x0011 holding 0x1044
//     -> DATA precedes FETCH, AmemRead=0x1234, BmemRead=0x1044, stall low on cycle 6.
//   4 Store: MeAaddr=0x8001, MeMemWrite=0xBEEF, ctrl=10 -> we_n low 1 cycle with
//     dq_oe=1 and dq_out=0xBEEF; a later read of 0x8001 returns 0xBEEF;
//     AmemRead unchanged.
//   5 Inputs toggled during stall, and ctrl=11 -> no effect on latched access;
//     ctrl=11 takes the 4-cycle fetch-only path.
//   6 Reset asserted during DATA write -> we_n=1 and dq_oe=0 immediately; after
//     release, the first cycle is ARB.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one asynchronous SRAM between the cpu data port and its instruction fetch port.
// Each cpu step runs ARB -> [DATA] -> FETCH -> DONE, and the pipeline is stalled everywhere except DONE.
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Baddr,
    output logic [DATA_W-1:0] BmemRead,
    input  logic [ADDR_W-1:0] MeAaddr,
    input  logic [DATA_W-1:0] MeMemWrite,
    input  logic [1:0]        MeMemControl,
    output logic [DATA_W-1:0] AmemRead,
    output logic              stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int T     = WAIT_CYCLES + 1;
    localparam int CNT_W = (T > 1) ? $clog2(T) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(T - 1);

    typedef enum logic [1:0] {ARB, DATA, FETCH, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_bAddr;
    logic [1:0]        r_op;
    logic              w_last;
    logic              w_opRead;
    logic              w_opWrite;
    logic              w_inIsData;

    assign w_last     = (r_cnt == LAST);
    assign w_opRead   = (r_op == 2'b01);
    assign w_opWrite  = (r_op == 2'b10);
    assign w_inIsData = (MeMemControl == 2'b01) || (MeMemControl == 2'b10);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB:     w_next = w_inIsData ? DATA : FETCH;
            DATA:    if (w_last) w_next = FETCH;
            FETCH:   if (w_last) w_next = DONE;
            DONE:    w_next = ARB;
            default: w_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // sram_addr is loaded one edge early so it is already valid on the first cycle of each access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bAddr     <= '0;
            r_op        <= 2'b00;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            AmemRead    <= '0;
            BmemRead    <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    r_bAddr     <= Baddr;
                    r_op        <= MeMemControl;
                    sram_dq_out <= MeMemWrite;
                    sram_addr   <= w_inIsData ? MeAaddr : Baddr;
                end
                DATA: begin
                    if (w_last) begin
                        if (w_opRead) AmemRead <= sram_dq_in;
                        sram_addr <= r_bAddr;
                    end
                end
                FETCH: begin
                    if (w_last) BmemRead <= sram_dq_in;
                end
                default: ;
            endcase
        end
    end

    // Write strobe is released on the final DATA cycle so address and data are held past the rising we_n.
    always_comb begin
        stall      = 1'b1;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (r_state)
            DATA: begin
                sram_ce_n = 1'b0;
                if (w_opRead) sram_oe_n = 1'b0;
                if (w_opWrite) begin
                    sram_dq_oe = 1'b1;
                    sram_we_n  = (T == 1) ? 1'b0 : w_last;
                end
            end
            FETCH: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            DONE:    stall = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: an SRAM model, a queue-based cpu reference model, and a scoreboard monitor.
// Transactions are issued with directed and random values, and expectations are popped on each DONE cycle.
module tb_mem_arbiter;

    localparam int TT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Baddr, MeAaddr, MeMemWrite;
    logic [1:0]  MeMemControl;
    logic [15:0] BmemRead, AmemRead;
    logic        stall;
    logic [15:0] sram_addr, sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    int checkCnt = 0;
    int passCnt  = 0;
    logic monOn = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .Baddr(Baddr), .BmemRead(BmemRead),
        .MeAaddr(MeAaddr), .MeMemWrite(MeMemWrite), .MeMemControl(MeMemControl),
        .AmemRead(AmemRead), .stall(stall),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    function automatic logic [15:0] initVal(input logic [15:0] a);
        case (a)
            16'h0010: return 16'h0800;
            16'h8000: return 16'h1234;
            16'h0011: return 16'h1044;
            default:  return 16'(a * 16'h9E37) ^ 16'h5A5A;
        endcase
    endfunction

    // Asynchronous SRAM: combinational read, and a write commits while ce_n and we_n are low with the bus driven.
    logic [15:0] sramMem [0:65535];
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sramMem[sram_addr] : 16'hDEAD;
    initial begin
        for (int i = 0; i < 65536; i++) sramMem[i] = initVal(16'(i));
        forever begin
            @(posedge clk);
            if (!sram_ce_n && !sram_we_n && sram_dq_oe) sramMem[sram_addr] <= sram_dq_out;
        end
    end

    logic [15:0] refStore [logic [15:0]];
    logic [15:0] refA = 16'h0000;

    function automatic logic [15:0] refRead(input logic [15:0] a);
        return refStore.exists(a) ? refStore[a] : initVal(a);
    endfunction

    typedef struct {
        logic [15:0] b;
        logic [15:0] a;
        int          cycles;
        int          ceLow;
        int          oeLow;
        int          weLow;
        int          dqoe;
        logic        isWrite;
        logic [15:0] wdata;
    } exp_t;

    exp_t expQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCnt++;
        if (actual === expected) passCnt++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Drives one cpu step, records its expected result, and scrambles the inputs once they have been latched.
    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] aAddr,
                                 input logic [15:0] wData, input logic [15:0] bAddr);
        exp_t e;
        logic isData;
        logic done;
        MeMemControl = op;
        MeAaddr      = aAddr;
        MeMemWrite   = wData;
        Baddr        = bAddr;
        isData = (op == 2'b01) || (op == 2'b10);
        if (op == 2'b01) refA = refRead(aAddr);
        if (op == 2'b10) refStore[aAddr] = wData;
        e.b       = refRead(bAddr);
        e.a       = refA;
        e.cycles  = isData ? 2 + 2 * TT : 2 + TT;
        e.ceLow   = isData ? 2 * TT : TT;
        e.oeLow   = (op == 2'b01) ? 2 * TT : TT;
        e.weLow   = (op == 2'b10) ? TT - 1 : 0;
        e.dqoe    = (op == 2'b10) ? TT : 0;
        e.isWrite = (op == 2'b10);
        e.wdata   = wData;
        expQ.push_back(e);
        @(negedge clk);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
            else begin
                Baddr        = 16'($urandom);
                MeAaddr      = 16'($urandom);
                MeMemWrite   = 16'($urandom);
                MeMemControl = 2'($urandom);
            end
        end
        checkOutput("doneReached", 32'(done), 32'd1);
    endtask

    int          cyc, ceL, oeL, weL, dqoeL, ovl;
    logic [15:0] seenW;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst || !monOn) begin
                cyc = 0; ceL = 0; oeL = 0; weL = 0; dqoeL = 0; ovl = 0; seenW = 16'h0;
            end else begin
                cyc++;
                if (!sram_ce_n) ceL++;
                if (!sram_oe_n) oeL++;
                if (!sram_we_n) begin weL++; seenW = sram_dq_out; end
                if (sram_dq_oe) dqoeL++;
                if (!sram_oe_n && !sram_we_n) ovl++;
                if (!stall) begin
                    checkOutput("pendingExpect", 32'(expQ.size() > 0), 32'd1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("BmemRead", 32'(BmemRead), 32'(e.b));
                        checkOutput("AmemRead", 32'(AmemRead), 32'(e.a));
                        checkOutput("stepCycles", 32'(cyc), 32'(e.cycles));
                        checkOutput("ceLowCycles", 32'(ceL), 32'(e.ceLow));
                        checkOutput("oeLowCycles", 32'(oeL), 32'(e.oeLow));
                        checkOutput("weLowCycles", 32'(weL), 32'(e.weLow));
                        checkOutput("dqOeCycles", 32'(dqoeL), 32'(e.dqoe));
                        checkOutput("oeWeOverlap", 32'(ovl), 32'd0);
                        if (e.isWrite) checkOutput("storeData", 32'(seenW), 32'(e.wdata));
                    end
                    cyc = 0; ceL = 0; oeL = 0; weL = 0; dqoeL = 0; ovl = 0;
                end
            end
        end
    end

    initial begin
        logic        weSeen;
        logic [15:0] r;
        rst = 1'b0;
        Baddr = 16'h0; MeAaddr = 16'h0; MeMemWrite = 16'h0; MeMemControl = 2'b00;
        repeat (5) @(negedge clk);
        checkOutput("rstStall", 32'(stall), 32'd1);
        checkOutput("rstBmem", 32'(BmemRead), 32'd0);
        checkOutput("rstAmem", 32'(AmemRead), 32'd0);
        checkOutput("rstStrobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        checkOutput("rstDqOe", 32'(sram_dq_oe), 32'd0);
        checkOutput("rstAddr", 32'(sram_addr), 32'd0);

        @(posedge clk); #1;
        rst = 1'b1;
        monOn = 1'b1;
        applyStimulus(2'b00, 16'h4444, 16'h0000, 16'h0010);
        applyStimulus(2'b01, 16'h8000, 16'h0000, 16'h0011);
        applyStimulus(2'b10, 16'h8001, 16'hBEEF, 16'h0010);
        applyStimulus(2'b01, 16'h8001, 16'h0000, 16'h0011);
        applyStimulus(2'b11, 16'h8000, 16'h1111, 16'h0010);

        for (int n = 0; n < 40; n++) begin
            r = 16'($urandom_range(0, 7));
            applyStimulus(2'($urandom_range(0, 3)), 16'h8000 + r, 16'($urandom),
                          ($urandom_range(0, 1) == 1) ? 16'h8000 + 16'($urandom_range(0, 7))
                                                     : 16'h0010 + r);
        end

        // Start a store, then pull reset while we_n is low; the store must be abandoned.
        MeMemControl = 2'b10; MeAaddr = 16'h8002; MeMemWrite = 16'hCAFE; Baddr = 16'h0010;
        @(negedge clk);
        monOn = 1'b0;
        checkOutput("queueIdle", 32'(expQ.size()), 32'd0);
        weSeen = 1'b0;
        for (int i = 0; i < 10 && !weSeen; i++) begin
            if (!sram_we_n) weSeen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("weLowBeforeReset", 32'(weSeen), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midRstWeN", 32'(sram_we_n), 32'd1);
        checkOutput("midRstDqOe", 32'(sram_dq_oe), 32'd0);
        checkOutput("midRstCeN", 32'(sram_ce_n), 32'd1);
        checkOutput("midRstStall", 32'(stall), 32'd1);
        checkOutput("midRstAmem", 32'(AmemRead), 32'd0);
        refA = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        monOn = 1'b1;
        applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h0011);
        applyStimulus(2'b01, 16'h8002, 16'h0000, 16'h0010);

        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
